// File: rtl/audio_clk_pkg.sv
// Shared constants and elaboration helpers for the I2S transmit clock/serialiser block.
// Defaults give BCLK = MCLK/6 = 3.072 MHz and fs = 48 kHz from an 18.432 MHz master clock.
package audio_clk_pkg;

  localparam int MCLK_HZ           = 18_432_000;
  localparam int DEF_BCLK_DIV      = 6;
  localparam int DEF_SLOT_BITS     = 32;
  localparam int DEF_DATA_W        = 24;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // BCLK must split into equal halves, and a sample needs the one-bit I2S delay slot.
  function automatic logic params_ok(input int bclk_div, input int slot_bits, input int data_w);
    return (bclk_div >= 2) && ((bclk_div % 2) == 0) &&
           (data_w >= 1) && (data_w <= slot_bits - 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop resynchroniser for slow asynchronous status inputs.
// Output follows the input two clock edges later; resets to all zeros.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Synchroniser chain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= {WIDTH{1'b0}};
      r_sync <= {WIDTH{1'b0}};
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/audio_i2s_tx_clkgen.sv
// I2S transmitter: derives BCLK/LRCK from the audio master clock and serialises
// stereo sample pairs, taken over valid/ready, MSB-first with the one-BCLK I2S delay.
module audio_i2s_tx_clkgen
  import audio_clk_pkg::*;
#(
  parameter int BCLK_DIV  = DEF_BCLK_DIV,
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              aud_bclk,
  output logic              aud_lrck,
  output logic              aud_dacdat,
  output logic              frame_tick,
  output logic              underrun
);

  localparam int DIV_W   = clog2(BCLK_DIV);
  localparam int BIT_W   = clog2(2 * SLOT_BITS);
  localparam int FRAME_W = 2 * SLOT_BITS;
  localparam int PAD_W   = SLOT_BITS - DATA_W;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  if (!params_ok(BCLK_DIV, SLOT_BITS, DATA_W)) begin : g_param_check
    $error("audio_i2s_tx_clkgen: BCLK_DIV must be even and >= 2, DATA_W <= SLOT_BITS-1");
  end

  logic               w_en;
  logic               w_fall_evt;
  logic               w_frame_load;
  logic               w_accept;
  logic [DIV_W-1:0]   w_div_next;
  logic [BIT_W-1:0]   w_bit_next;
  logic [FRAME_W-1:0] w_frame_word;

  logic [DIV_W-1:0]   r_div_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic               r_empty;
  logic [DATA_W-1:0]  r_hold_l;
  logic [DATA_W-1:0]  r_hold_r;
  logic [FRAME_W-1:0] r_shift;
  logic               r_bclk;
  logic               r_lrck;
  logic               r_dacdat;
  logic               r_frame_tick;
  logic               r_underrun;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (pll_locked),
    .o_q     (w_en)
  );

  assign w_accept = s_valid && r_empty;

  // Each slot is sample then zero padding; the serialiser emits a 0 on the load
  // cycle, which supplies the one-BCLK MSB delay.
  assign w_frame_word = {r_hold_l, {PAD_W{1'b0}}, r_hold_r, {PAD_W{1'b0}}};

  // Divider and bit-position next-state; idle values park both counters on
  // their last count so the first enabled cycle is a frame-load fall event.
  always_comb begin
    w_fall_evt   = 1'b0;
    w_div_next   = DIV_LAST;
    w_bit_next   = BIT_LAST;
    w_frame_load = 1'b0;
    if (w_en) begin
      if (r_div_cnt == DIV_LAST) begin
        w_div_next = DIV_ZERO;
        w_fall_evt = 1'b1;
      end else begin
        w_div_next = r_div_cnt + DIV_ONE;
        w_fall_evt = 1'b0;
      end
      if (w_fall_evt) begin
        if (r_bit_cnt == BIT_LAST) begin
          w_bit_next = BIT_ZERO;
        end else begin
          w_bit_next = r_bit_cnt + BIT_ONE;
        end
      end else begin
        w_bit_next = r_bit_cnt;
      end
      w_frame_load = w_fall_evt && (w_bit_next == BIT_ZERO);
    end else begin
      w_fall_evt   = 1'b0;
      w_div_next   = DIV_LAST;
      w_bit_next   = BIT_LAST;
      w_frame_load = 1'b0;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= DIV_LAST;
      r_bit_cnt <= BIT_LAST;
    end else begin
      r_div_cnt <= w_div_next;
      r_bit_cnt <= w_bit_next;
    end
  end

  // Holding register and handshake; a load in the accept cycle sees it empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_empty  <= 1'b1;
      r_hold_l <= {DATA_W{1'b0}};
      r_hold_r <= {DATA_W{1'b0}};
    end else if (w_frame_load && !r_empty) begin
      r_empty <= 1'b1;
    end else if (w_accept) begin
      r_empty  <= 1'b0;
      r_hold_l <= s_left;
      r_hold_r <= s_right;
    end else begin
      r_empty <= r_empty;
    end
  end

  // Pin-side outputs and shift register; LRCK/data only move on BCLK falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bclk       <= 1'b0;
      r_lrck       <= 1'b0;
      r_dacdat     <= 1'b0;
      r_frame_tick <= 1'b0;
      r_underrun   <= 1'b0;
      r_shift      <= {FRAME_W{1'b0}};
    end else if (!w_en) begin
      r_bclk       <= 1'b0;
      r_lrck       <= 1'b0;
      r_dacdat     <= 1'b0;
      r_frame_tick <= 1'b0;
      r_underrun   <= 1'b0;
      r_shift      <= {FRAME_W{1'b0}};
    end else begin
      r_bclk       <= (w_div_next >= DIV_HALF);
      r_frame_tick <= w_frame_load;
      r_underrun   <= w_frame_load && r_empty;
      if (w_frame_load) begin
        r_lrck   <= 1'b0;
        r_dacdat <= 1'b0;
        r_shift  <= r_empty ? {FRAME_W{1'b0}} : w_frame_word;
      end else if (w_fall_evt) begin
        r_lrck   <= (w_bit_next >= BIT_SLOT);
        r_dacdat <= r_shift[FRAME_W-1];
        r_shift  <= {r_shift[FRAME_W-2:0], 1'b0};
      end else begin
        r_lrck   <= r_lrck;
        r_dacdat <= r_dacdat;
        r_shift  <= r_shift;
      end
    end
  end

  assign s_ready    = r_empty;
  assign aud_bclk   = r_bclk;
  assign aud_lrck   = r_lrck;
  assign aud_dacdat = r_dacdat;
  assign frame_tick = r_frame_tick;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_audio_i2s_tx_clkgen.sv
// Directed self-checking bench for audio_i2s_tx_clkgen with default parameters
// (6 clk per BCLK, 32-bit slots, 24-bit samples, 384 clk per frame).
module tb_audio_i2s_tx_clkgen;

  logic        clk;
  logic        reset_n;
  logic        pll_locked;
  logic [23:0] s_left;
  logic [23:0] s_right;
  logic        s_valid;
  logic        s_ready;
  logic        aud_bclk;
  logic        aud_lrck;
  logic        aud_dacdat;
  logic        frame_tick;
  logic        underrun;

  int n_checks;
  int n_fails;

  audio_i2s_tx_clkgen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .s_left     (s_left),
    .s_right    (s_right),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .aud_bclk   (aud_bclk),
    .aud_lrck   (aud_lrck),
    .aud_dacdat (aud_dacdat),
    .frame_tick (frame_tick),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected data bit during BCLK period b of a frame carrying (l, r).
  function automatic logic exp_dac(input logic [23:0] l, input logic [23:0] r, input int b);
    logic [23:0] lv;
    logic [23:0] rv;
    lv = l;
    rv = r;
    if (b >= 1 && b <= 24) return lv[24 - b];
    else if (b >= 33 && b <= 56) return rv[56 - b];
    else return 1'b0;
  endfunction

  function automatic logic [23:0] pat_l(input int n);
    return 24'h800001 + 24'(n) * 24'h010203;
  endfunction

  function automatic logic [23:0] pat_r(input int n);
    return ~pat_l(n);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; pll_locked = 1'b0; s_valid = 1'b0;
    s_left = 24'h000000; s_right = 24'h000000;
    tick(); tick(); tick();
    n_checks++;
    if ({s_ready, aud_bclk, aud_lrck, aud_dacdat, frame_tick, underrun} !== 6'b100000) begin
      n_fails++;
      $display("FAIL reset_state: got %b expected 100000",
               {s_ready, aud_bclk, aud_lrck, aud_dacdat, frame_tick, underrun});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_lock_gating();
    for (int i = 0; i < 100; i++) begin
      tick();
      n_checks++;
      if ({aud_bclk, aud_lrck, aud_dacdat, frame_tick, underrun} !== 5'b00000) begin
        n_fails++;
        $display("FAIL unlocked_idle cycle %0d: got %b expected 00000", i,
                 {aud_bclk, aud_lrck, aud_dacdat, frame_tick, underrun});
      end
    end
    pll_locked = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_checks++;
      if ({aud_bclk, aud_lrck, aud_dacdat, frame_tick, underrun} !== 5'b00000) begin
        n_fails++;
        $display("FAIL lock_sync_delay edge %0d: got %b expected 00000", i,
                 {aud_bclk, aud_lrck, aud_dacdat, frame_tick, underrun});
      end
    end
    tick();
    n_checks++;
    if ({frame_tick, underrun} !== 2'b11) begin
      n_fails++;
      $display("FAIL first_frame_tick: got tick/underrun %b expected 11", {frame_tick, underrun});
    end
    for (int j = 1; j <= 192; j++) begin
      tick();
      n_checks++;
      if (aud_lrck !== (j >= 192) || aud_bclk !== ((j % 6) >= 3) || aud_dacdat !== 1'b0) begin
        n_fails++;
        $display("FAIL lrck_bclk_gating j=%0d: got lrck/bclk/dat %b%b%b expected %b%b0", j,
                 aud_lrck, aud_bclk, aud_dacdat, (j >= 192), ((j % 6) >= 3));
      end
    end
  endtask

  task automatic test_left_sample();
    logic found;
    s_valid = 1'b1; s_left = 24'hA5A5A5; s_right = 24'h3C3C3C;
    tick();
    s_valid = 1'b0;
    n_checks++;
    if (s_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL preload_ready: got %b expected 0", s_ready);
    end
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      if (frame_tick === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fails++;
      $display("FAIL left_wait_frame: got no frame_tick within 400 cycles, expected one");
    end
    n_checks++;
    if ({underrun, s_ready} !== 2'b01) begin
      n_fails++;
      $display("FAIL left_load: got underrun/ready %b expected 01", {underrun, s_ready});
    end
    for (int j = 0; j < 384; j++) begin
      if (j > 0) tick();
      n_checks++;
      if (aud_bclk !== ((j % 6) >= 3) || aud_lrck !== ((j / 6) >= 32) ||
          aud_dacdat !== exp_dac(24'hA5A5A5, 24'h3C3C3C, j / 6)) begin
        n_fails++;
        $display("FAIL left_sample_serial j=%0d: got bclk/lrck/dat %b%b%b expected %b%b%b", j,
                 aud_bclk, aud_lrck, aud_dacdat, ((j % 6) >= 3), ((j / 6) >= 32),
                 exp_dac(24'hA5A5A5, 24'h3C3C3C, j / 6));
      end
    end
  endtask

  task automatic test_underrun();
    tick();
    n_checks++;
    if ({frame_tick, underrun} !== 2'b11) begin
      n_fails++;
      $display("FAIL underrun_first: got tick/underrun %b expected 11", {frame_tick, underrun});
    end
    for (int f = 0; f < 2; f++) begin
      for (int j = 1; j <= 384; j++) begin
        tick();
        n_checks++;
        if (j < 384) begin
          if ({frame_tick, underrun, aud_dacdat} !== 3'b000) begin
            n_fails++;
            $display("FAIL underrun_quiet f=%0d j=%0d: got tick/underrun/dat %b expected 000",
                     f, j, {frame_tick, underrun, aud_dacdat});
          end
        end else begin
          if ({frame_tick, underrun} !== 2'b11) begin
            n_fails++;
            $display("FAIL underrun_period f=%0d: got tick/underrun %b expected 11",
                     f, {frame_tick, underrun});
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int          n_drv;
    int          acc;
    logic        pending;
    logic [23:0] got_l;
    logic [23:0] got_r;
    n_drv = 0;
    s_valid = 1'b1; s_left = pat_l(0); s_right = pat_r(0);
    for (int f = 0; f < 4; f++) begin
      acc = 0; got_l = 24'h000000; got_r = 24'h000000;
      for (int j = 1; j <= 384; j++) begin
        pending = (s_valid === 1'b1) && (s_ready === 1'b1);
        tick();
        if (pending) begin
          acc++;
          n_checks++;
          if (s_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL b2b_ready_fall f=%0d: got %b expected 0", f, s_ready);
          end
          n_drv++;
          s_left = pat_l(n_drv); s_right = pat_r(n_drv);
        end
        if (j < 384) begin
          if ((j % 6) == 3 && (j / 6) >= 1 && (j / 6) <= 24) got_l[24 - j / 6] = aud_dacdat;
          if ((j % 6) == 3 && (j / 6) >= 33 && (j / 6) <= 56) got_r[56 - j / 6] = aud_dacdat;
        end else begin
          n_checks++;
          if ({frame_tick, underrun, s_ready} !== 3'b101) begin
            n_fails++;
            $display("FAIL b2b_load f=%0d: got tick/underrun/ready %b expected 101",
                     f, {frame_tick, underrun, s_ready});
          end
        end
      end
      n_checks++;
      if (acc != 1) begin
        n_fails++;
        $display("FAIL b2b_accepts f=%0d: got %0d expected 1", f, acc);
      end
      if (f >= 1) begin
        n_checks++;
        if (got_l !== pat_l(f - 1) || got_r !== pat_r(f - 1)) begin
          n_fails++;
          $display("FAIL b2b_data f=%0d: got %h/%h expected %h/%h", f, got_l, got_r,
                   pat_l(f - 1), pat_r(f - 1));
        end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_collision();
    logic        saw_one;
    logic [23:0] got_l;
    logic [23:0] got_r;
    for (int j = 1; j < 384; j++) tick();
    s_valid = 1'b1; s_left = 24'h123456; s_right = 24'hFEDCBA;
    tick();
    s_valid = 1'b0;
    n_checks++;
    if ({frame_tick, underrun, s_ready} !== 3'b110) begin
      n_fails++;
      $display("FAIL collision_load: got tick/underrun/ready %b expected 110",
               {frame_tick, underrun, s_ready});
    end
    saw_one = 1'b0;
    for (int j = 1; j <= 384; j++) begin
      tick();
      if (j < 384 && aud_dacdat === 1'b1) saw_one = 1'b1;
    end
    n_checks++;
    if (saw_one !== 1'b0) begin
      n_fails++;
      $display("FAIL collision_silent: got data 1 in underrun frame, expected all 0");
    end
    n_checks++;
    if ({frame_tick, underrun, s_ready} !== 3'b101) begin
      n_fails++;
      $display("FAIL collision_next_load: got tick/underrun/ready %b expected 101",
               {frame_tick, underrun, s_ready});
    end
    got_l = 24'h000000; got_r = 24'h000000;
    for (int j = 1; j < 384; j++) begin
      tick();
      if ((j % 6) == 3 && (j / 6) >= 1 && (j / 6) <= 24) got_l[24 - j / 6] = aud_dacdat;
      if ((j % 6) == 3 && (j / 6) >= 33 && (j / 6) <= 56) got_r[56 - j / 6] = aud_dacdat;
    end
    n_checks++;
    if (got_l !== 24'h123456 || got_r !== 24'hFEDCBA) begin
      n_fails++;
      $display("FAIL collision_data: got %h/%h expected 123456/fedcba", got_l, got_r);
    end
  endtask

  task automatic test_lock_loss();
    logic [23:0] got_l;
    logic [23:0] got_r;
    tick();
    n_checks++;
    if ({frame_tick, underrun} !== 2'b11) begin
      n_fails++;
      $display("FAIL loss_pre_underrun: got tick/underrun %b expected 11", {frame_tick, underrun});
    end
    s_valid = 1'b1; s_left = 24'h5A0F33; s_right = 24'h0C0FFE;
    tick();
    s_valid = 1'b0;
    for (int j = 2; j <= 384; j++) tick();
    n_checks++;
    if ({frame_tick, underrun, s_ready} !== 3'b101) begin
      n_fails++;
      $display("FAIL loss_load: got tick/underrun/ready %b expected 101",
               {frame_tick, underrun, s_ready});
    end
    s_valid = 1'b1; s_left = 24'h7E5A81; s_right = 24'h81A57E;
    tick();
    s_valid = 1'b0;
    for (int j = 2; j <= 60; j++) begin
      tick();
      if ((j % 6) == 3 && (j / 6) >= 1) begin
        n_checks++;
        if (aud_dacdat !== exp_dac(24'h5A0F33, 24'h0C0FFE, j / 6)) begin
          n_fails++;
          $display("FAIL loss_left_bits bit=%0d: got %b expected %b", j / 6, aud_dacdat,
                   exp_dac(24'h5A0F33, 24'h0C0FFE, j / 6));
        end
      end
    end
    pll_locked = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if ({aud_bclk, aud_lrck, aud_dacdat, frame_tick, underrun, s_ready} !== 6'b000000) begin
        n_fails++;
        $display("FAIL loss_idle i=%0d: got %b expected 000000", i,
                 {aud_bclk, aud_lrck, aud_dacdat, frame_tick, underrun, s_ready});
      end
      tick();
    end
    pll_locked = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if ({frame_tick, underrun, s_ready} !== 3'b101) begin
      n_fails++;
      $display("FAIL relock_load: got tick/underrun/ready %b expected 101",
               {frame_tick, underrun, s_ready});
    end
    got_l = 24'h000000; got_r = 24'h000000;
    for (int j = 1; j < 384; j++) begin
      tick();
      if ((j % 6) == 3 && (j / 6) >= 1 && (j / 6) <= 24) got_l[24 - j / 6] = aud_dacdat;
      if ((j % 6) == 3 && (j / 6) >= 33 && (j / 6) <= 56) got_r[56 - j / 6] = aud_dacdat;
    end
    n_checks++;
    if (got_l !== 24'h7E5A81 || got_r !== 24'h81A57E) begin
      n_fails++;
      $display("FAIL relock_data: got %h/%h expected 7e5a81/81a57e", got_l, got_r);
    end
  endtask

  task automatic test_async_reset();
    tick();
    n_checks++;
    if ({frame_tick, underrun} !== 2'b11) begin
      n_fails++;
      $display("FAIL rst_pre_underrun: got tick/underrun %b expected 11", {frame_tick, underrun});
    end
    s_valid = 1'b1; s_left = 24'h111111; s_right = 24'h222222;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 200; i++) tick();
    n_checks++;
    if ({aud_lrck, s_ready} !== 2'b10) begin
      n_fails++;
      $display("FAIL rst_pre_state: got lrck/ready %b expected 10", {aud_lrck, s_ready});
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({s_ready, aud_bclk, aud_lrck, aud_dacdat, frame_tick, underrun} !== 6'b100000) begin
      n_fails++;
      $display("FAIL async_reset: got %b expected 100000",
               {s_ready, aud_bclk, aud_lrck, aud_dacdat, frame_tick, underrun});
    end
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_lock_gating();
    test_left_sample();
    test_underrun();
    test_back_to_back();
    test_collision();
    test_lock_loss();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx_clkgen.md
Name: audio_i2s_tx_clkgen

Overview:
- Consumes the 18.432 MHz audio master clock and PLL lock flag from the audio PLL stage.
- Derives I2S bit clock (BCLK) and left/right clock (LRCK) from that clock.
- Serialises stereo samples, accepted over a valid/ready handshake, onto the codec DAC data line.
- Sits between the audio PLL and the codec pins. With defaults it produces BCLK 3.072 MHz and fs 48 kHz.

Parameters:
- BCLK_DIV, 6, clk cycles per BCLK period; even, >= 2.
- SLOT_BITS, 32, BCLK periods per channel slot.
- DATA_W, 24, sample width; DATA_W <= SLOT_BITS-1.

Ports:
- clk  in  1  audio master clock (PLL outclk_0).
- reset_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL locked flag; asynchronous to clk.
- s_left  in  DATA_W  left sample, two's complement.
- s_right  in  DATA_W  right sample, two's complement.
- s_valid  in  1  sample pair valid.
- s_ready  out  1  holding register empty.
- aud_bclk  out  1  I2S bit clock.
- aud_lrck  out  1  I2S word select; 0 = left.
- aud_dacdat  out  1  serial DAC data.
- frame_tick  out  1  one-cycle pulse at each frame load.
- underrun  out  1  one-cycle pulse when a frame loads with no sample held.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous, active-low, on reset_n.
- All outputs are registered.
- Reset values: s_ready=1, aud_bclk=0, aud_lrck=0, aud_dacdat=0, frame_tick=0, underrun=0. Holding register is empty.
- pll_locked passes through a 2-flop synchroniser to give en. en goes high 2 clk edges after pll_locked rises.
- While en=0:
  - div_cnt is held at BCLK_DIV-1 and bit_cnt at 2*SLOT_BITS-1.
  - aud_bclk, aud_lrck, aud_dacdat, frame_tick and underrun are held at 0.
  - The shift register is cleared. The holding register and handshake keep operating.
- While en=1:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - aud_bclk is registered as (div_cnt_next >= BCLK_DIV/2).
  - fall_evt is the cycle where div_cnt wraps BCLK_DIV-1 -> 0. The first en=1 cycle is therefore a fall_evt.
- On fall_evt:
  - bit_cnt increments, mod 2*SLOT_BITS.
  - aud_lrck <= (bit_cnt_next >= SLOT_BITS).
  - With k = bit_cnt_next mod SLOT_BITS: aud_dacdat <= sample[DATA_W-k] of the current channel for 1 <= k <= DATA_W, else 0. This gives the I2S one-BCLK MSB delay.
  - Data and LRCK change only on BCLK falling edges, so the codec samples them on rising edges.
- Frame load occurs on a fall_evt where bit_cnt_next == 0:
  - If the holding register is full: shift register <= {left, right}, holding register becomes empty, frame_tick=1.
  - If it is empty: shift register <= 0, frame_tick=1 and underrun=1, both for that cycle.
- Handshake:
  - s_ready = holding register empty (registered, no combinational path from s_valid).
  - Accept occurs when s_valid && s_ready, and the holding register becomes full the next cycle.
  - When accept and frame load happen in the same cycle with the register empty, the load sees it empty (underrun). The new pair is held for the next frame.
  - s_left and s_right are sampled only at accept.
- Frame rate = f_clk/(BCLK_DIV*2*SLOT_BITS); 384 clk cycles with the defaults.
- pll_locked drop mid-frame: after en falls, outputs return to idle values on the next edge. The partial frame is discarded and the holding register is retained. On relock, a frame load occurs on the first en=1 cycle.
- reset_n assertion mid-frame clears all state immediately (asynchronously).
- Counter widths: div_cnt is clog2(BCLK_DIV) bits, bit_cnt is clog2(2*SLOT_BITS) bits. Wrap is explicit by compare, not by overflow.

Decomposition:
- Package audio_clk_pkg holds:
  - MCLK_HZ = 18_432_000.
  - Default BCLK_DIV, SLOT_BITS and DATA_W constants.
  - A clog2 function.
  - Elaboration checks for the parameter constraints.
- One sub-module, sync_2ff, resynchronises pll_locked. It is reusable for other asynchronous status inputs.

Test Plan:
- Lock gating: hold pll_locked=0 for 100 cycles, then raise it -> all outputs 0 throughout. frame_tick on the 3rd edge after the rise. aud_lrck stays 0 for 192 cycles, then goes to 1.
- Left sample: s_left=24'hA5A5A5, s_right=24'h3C3C3C preloaded -> BCLK period 6 clk with 50% duty. On BCLK rising edges, the left slot reads 0, then A5A5A5 MSB-first, then 7 zeros. The right slot reads 0, then 3C3C3C MSB-first.
- Underrun: no s_valid -> underrun=1 together with frame_tick every 384 cycles; aud_dacdat constant 0.
- Back-to-back: s_valid held high with an incrementing pattern -> exactly one accept per frame. s_ready falls one cycle after accept and rises one cycle after frame load. No underrun after the first frame.
- Same-cycle collision: with the register empty, assert s_valid in the frame-load cycle -> underrun=1 that frame. The pair is serialised in the following frame.
- Lock loss and reset: drop pll_locked at bit 10 of the left slot -> outputs idle 2–3 cycles later, held pair preserved, frame load on relock. Assert reset_n=0 mid-slot -> outputs 0 and s_ready=1 with no clk edge required.
